// File: rtl/lab2_proc_imul_pkg.sv
// Shared types and sizing for the iterative multiplier; no logic, no latency.
// Backpressure is handled by the val/rdy FSM in lab2_proc_imul_iter.
package lab2_proc_imul_pkg;

    typedef enum logic [1:0] {
        IMUL_IDLE,
        IMUL_CALC,
        IMUL_DONE
    } imul_state_e;

    localparam int IMUL_NBITS = 32;

endpackage

// File: rtl/lab2_proc_imul_iter_dpath.sv
// Shift-and-add datapath: operand/result/counter registers, one partial product per step.
// One cycle per load/shift step; holds all state whenever neither enable is asserted.
// Option LAB2_PROC_IMUL_EARLY_EXIT_EN additionally exports b_zero.
module lab2_proc_imul_iter_dpath
    import lab2_proc_imul_pkg::*;
#(
    parameter int NBITS = IMUL_NBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic             add_en,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic             b_lsb,
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
    output logic             b_zero,
`endif
    output logic             cnt_last,
    output logic [NBITS-1:0] result
);

    localparam int CW = $clog2(NBITS) + 1;

    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] result_q, result_d;
    logic [CW-1:0]    counter_q, counter_d;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        counter_d = counter_q;
        if (load_en) begin
            a_d       = req_a;
            b_d       = req_b;
            result_d  = '0;
            counter_d = '0;
        end else if (shift_en) begin
            if (add_en) begin
                result_d = result_q + a_q;
            end
            a_d       = a_q << 1;
            b_d       = b_q >> 1;
            counter_d = counter_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            counter_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            counter_q <= counter_d;
        end
    end

    assign b_lsb    = b_q[0];
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
    assign b_zero   = (b_q == '0);
`endif
    assign cnt_last = (counter_q == CW'(NBITS - 1));
    assign result   = result_q;

endmodule

// File: rtl/lab2_proc_imul_iter.sv
// Iterative NBITS x NBITS multiplier (low half of product) with val/rdy request/response.
// Latency NBITS CALC cycles; with LAB2_PROC_IMUL_EARLY_EXIT_EN, stops once b_reg drains to zero.
// One operation in flight; DONE holds result until resp_rdy, req_rdy low outside IDLE.
module lab2_proc_imul_iter
    import lab2_proc_imul_pkg::*;
#(
    parameter int NBITS = IMUL_NBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg
);

    imul_state_e state_q, state_d;
    logic        req_rdy_q, req_rdy_d;
    logic        resp_val_q, resp_val_d;
    logic        load_en, shift_en, add_en;
    logic        b_lsb, cnt_last;
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
    logic        b_zero;
`endif

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        shift_en = 1'b0;
        add_en   = 1'b0;
        case (state_q)
            IMUL_IDLE: begin
                if (req_val) begin
                    load_en = 1'b1;
                    state_d = IMUL_CALC;
                end
            end
            IMUL_CALC: begin
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
                // Remaining multiplier bits are all zero: result is already final.
                if (b_zero) begin
                    state_d = IMUL_DONE;
                end else begin
                    shift_en = 1'b1;
                    add_en   = b_lsb;
                    if (cnt_last) state_d = IMUL_DONE;
                end
`else
                shift_en = 1'b1;
                add_en   = b_lsb;
                if (cnt_last) state_d = IMUL_DONE;
`endif
            end
            IMUL_DONE: begin
                if (resp_rdy) state_d = IMUL_IDLE;
            end
            default: state_d = IMUL_IDLE;
        endcase
        req_rdy_d  = (state_d == IMUL_IDLE);
        resp_val_d = (state_d == IMUL_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IMUL_IDLE;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_rdy_q  <= req_rdy_d;
            resp_val_q <= resp_val_d;
        end
    end

    lab2_proc_imul_iter_dpath #(.NBITS(NBITS)) u_dpath (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_en  (load_en),
        .shift_en (shift_en),
        .add_en   (add_en),
        .req_a    (req_a),
        .req_b    (req_b),
        .b_lsb    (b_lsb),
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
        .b_zero   (b_zero),
`endif
        .cnt_last (cnt_last),
        .result   (resp_msg)
    );

    assign req_rdy  = req_rdy_q;
    assign resp_val = resp_val_q;

endmodule

// File: tb/tb_lab2_proc_imul_iter.sv
// Directed and random checks for lab2_proc_imul_iter (either LAB2_PROC_IMUL_EARLY_EXIT_EN build).
module tb_lab2_proc_imul_iter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_val = 1'b0;
    logic        req_rdy;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_val;
    logic        resp_rdy = 1'b0;
    logic [31:0] resp_msg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lab2_proc_imul_iter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    function automatic int exp_lat(input logic [31:0] b);
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        if (msb + 2 > 32) return 32;
        return msb + 2;
`else
        return (b == 32'd0) ? 32 : 32;
`endif
    endfunction

    // Issue one request, wait for resp_val; leaves the DUT in DONE.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit got);
        req_a   = a;
        req_b   = b;
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        lat = 0;
        while (!resp_val && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        got = resp_val;
        res = resp_msg;
    endtask

    task automatic drain();
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        n_tests++;
        if (req_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_rdy got=%b want=1", req_rdy);
        end
        n_tests++;
        if (resp_val !== 1'b0) begin
            n_fail++; $display("FAIL reset_resp_val got=%b want=0", resp_val);
        end
        n_tests++;
        if (resp_msg !== 32'd0) begin
            n_fail++; $display("FAIL reset_resp_msg got=%h want=0", resp_msg);
        end
    endtask

    task automatic test_basic();
        logic [31:0] res; int lat; bit got;
        int want_lat;
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
        want_lat = 4;
`else
        want_lat = 32;
`endif
        issue(32'd3, 32'd4, res, lat, got);
        n_tests++;
        if (!got || res !== 32'd12) begin
            n_fail++; $display("FAIL basic_3x4 got=%h (vld=%b) want=0000000c", res, got);
        end
        n_tests++;
        if (lat !== want_lat) begin
            n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, want_lat);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] vb [3] = '{32'd2,         32'd6,         32'h8000_0000};
        logic [31:0] ve [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFD6, 32'h0000_0000};
        logic [31:0] res; int lat; bit got;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], res, lat, got);
            n_tests++;
            if (!got || res !== ve[i]) begin
                n_fail++; $display("FAIL wrap_%0d got=%h (vld=%b) want=%h", i, res, got, ve[i]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res; int lat; bit got;
        issue(32'd6, 32'd7, res, lat, got);
        n_tests++;
        if (!got || res !== 32'd42) begin
            n_fail++; $display("FAIL bp_result got=%h (vld=%b) want=0000002a", res, got);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (resp_val !== 1'b1 || resp_msg !== 32'd42 || req_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got vld=%b msg=%h rdy=%b want vld=1 msg=0000002a rdy=0",
                         i, resp_val, resp_msg, req_rdy);
            end
        end
        drain();
        n_tests++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", req_rdy, resp_val);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; int lat; bit got;
        req_a   = 32'd9;
        req_b   = 32'd9;
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1 || resp_msg !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid got vld=%b rdy=%b msg=%h want vld=0 rdy=1 msg=0",
                     resp_val, req_rdy, resp_msg);
        end
        reset_n = 1'b1;
        issue(32'd5, 32'd5, res, lat, got);
        n_tests++;
        if (!got || res !== 32'd25) begin
            n_fail++; $display("FAIL reset_mid_next got=%h (vld=%b) want=00000019", res, got);
        end
        drain();
    endtask

    task automatic test_zero_b();
        logic [31:0] res; int lat; bit got;
        int want_lat;
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
        want_lat = 1;
`else
        want_lat = 32;
`endif
        issue(32'd123, 32'd0, res, lat, got);
        n_tests++;
        if (!got || res !== 32'd0) begin
            n_fail++; $display("FAIL zero_b_result got=%h (vld=%b) want=0", res, got);
        end
        n_tests++;
        if (lat !== want_lat) begin
            n_fail++; $display("FAIL zero_b_latency got=%0d want=%0d", lat, want_lat);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, want;
        int lat, stall; bit got;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            want = a * b;
            stall = $urandom_range(0, 3);
            issue(a, b, res, lat, got);
            n_tests++;
            if (!got || res !== want) begin
                n_fail++; $display("FAIL rand_%0d a=%h b=%h got=%h want=%h", i, a, b, res, want);
            end
            n_tests++;
            if (lat !== exp_lat(b)) begin
                n_fail++; $display("FAIL rand_lat_%0d b=%h got=%0d want=%0d", i, b, lat, exp_lat(b));
            end
            repeat (stall) begin @(posedge clk); #1; end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_zero_b();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
